// File: rtl/regfile_32x32_dump_pkg.sv
// Shared widths, zero-register index and dump FSM encodings for the
// 32x32 MIPS register file with debug dump reader.
package regfile_32x32_dump_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned REG_ZERO   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } dump_state_e;

endpackage

// File: rtl/regfile_32x32_dump_if.sv
// Write, read and dump-stream signals of the register file.
// master = pipeline/debug side, slave = register file.
interface regfile_32x32_dump_if
  import regfile_32x32_dump_pkg::*;
#(
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned DATA_W = REG_DATA_W
) ();

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              dump_start;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              dump_busy;
  logic              dump_done;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, dump_start, dump_ready,
    input  rd_data_a, rd_data_b, dump_valid, dump_addr, dump_data, dump_busy, dump_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, dump_start, dump_ready,
    output rd_data_a, rd_data_b, dump_valid, dump_addr, dump_data, dump_busy, dump_done
  );

endinterface

// File: rtl/regfile_32x32_dump_ctrl.sv
// Dump sequencer: walks the index 0..DEPTH-1 over a valid/ready stream,
// then pulses done for one cycle.
module regfile_dump_ctrl
  import regfile_32x32_dump_pkg::*;
#(
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              dump_start,
  input  logic              dump_ready,
  output logic              dump_valid,
  output logic              dump_busy,
  output logic              dump_done,
  output logic [ADDR_W-1:0] dump_addr
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_d;

  // Flags are registered from the next state so they align with state_q.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      dump_addr  <= '0;
      dump_valid <= 1'b0;
      dump_busy  <= 1'b0;
      dump_done  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dump_addr  <= idx_d;
      dump_valid <= (state_d == ST_SCAN);
      dump_busy  <= (state_d == ST_SCAN);
      dump_done  <= (state_d == ST_DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = dump_addr;
    unique case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (dump_start) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (dump_ready) begin
          if (dump_addr == LAST_IDX) state_d = ST_DONE;
          else                       idx_d   = dump_addr + ADDR_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/regfile_32x32_dump.sv
// MIPS GPR file: one write port, two registered read ports with
// write-through bypass, and a combinational dump read port.
module regfile_32x32_dump
  import regfile_32x32_dump_pkg::*;
#(
  parameter int unsigned DATA_W   = REG_DATA_W,
  parameter int unsigned ADDR_W   = REG_ADDR_W,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  regfile_32x32_dump_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_ok;
  logic [DATA_W-1:0] rd_next_a;
  logic [DATA_W-1:0] rd_next_b;
  logic [ADDR_W-1:0] dump_idx;

  // Writes to the hardwired zero register never land, so regs[0] stays 0.
  assign wr_ok = bus.wr_en && !(ZERO_REG && (bus.wr_addr == ZERO_IDX));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    rd_next_a = regs[bus.rd_addr_a];
    rd_next_b = regs[bus.rd_addr_b];
    if (wr_ok && (bus.wr_addr == bus.rd_addr_a)) rd_next_a = bus.wr_data;
    if (wr_ok && (bus.wr_addr == bus.rd_addr_b)) rd_next_b = bus.wr_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.rd_data_a <= '0;
      bus.rd_data_b <= '0;
    end else begin
      bus.rd_data_a <= rd_next_a;
      bus.rd_data_b <= rd_next_b;
    end
  end

  regfile_dump_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_dump_ctrl (
    .clock      (clock),
    .reset_n    (reset_n),
    .dump_start (bus.dump_start),
    .dump_ready (bus.dump_ready),
    .dump_valid (bus.dump_valid),
    .dump_busy  (bus.dump_busy),
    .dump_done  (bus.dump_done),
    .dump_addr  (dump_idx)
  );

  // Dump data reflects the array as stored, so a stalled beat sees late writes.
  assign bus.dump_addr = dump_idx;
  assign bus.dump_data = regs[dump_idx];

endmodule

// File: doc/regfile_32x32_dump.md
Name: regfile_32x32_dump

Overview:
- 32-entry × 32-bit MIPS general-purpose register file.
- One write port, two registered read ports, and a debug dump reader.
- The dump reader streams every register out over a valid/ready handshake, so a bench or debug UART can read the whole architectural state.
- Sits between decode (read ports), writeback (write port) and the debug/trace logic.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth is 2**ADDR_W.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write index.
- wr_data  in  DATA_W  write data.
- rd_addr_a  in  ADDR_W  read port A index.
- rd_addr_b  in  ADDR_W  read port B index.
- rd_data_a  out  DATA_W  read port A data, one-cycle latency.
- rd_data_b  out  DATA_W  read port B data, one-cycle latency.
- dump_start  in  1  single-cycle request to begin a full dump.
- dump_valid  out  1  dump beat present.
- dump_ready  in  1  consumer accepts the current beat.
- dump_addr  out  ADDR_W  index of the current beat.
- dump_data  out  DATA_W  contents of register dump_addr.
- dump_busy  out  1  dump in progress (SCAN state).
- dump_done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (reset_n low, asynchronous):
  - all 32 registers clear to 0;
  - rd_data_a and rd_data_b clear to 0;
  - FSM goes to IDLE with index 0;
  - dump_valid, dump_busy and dump_done are 0; dump_addr is 0.
- Reset mid-dump aborts the dump with no done pulse.
- Write:
  - on a rising edge with wr_en=1, regs[wr_addr] <= wr_data;
  - with ZERO_REG=1, writes to address 0 are discarded.
- Read:
  - on every rising edge, rd_data_x <= value of regs[rd_addr_x];
  - latency is exactly 1 cycle.
- Write-read bypass:
  - applies when wr_en=1, wr_addr==rd_addr_x, and the address is not 0 (with ZERO_REG=1);
  - the captured rd_data_x is wr_data (the new value), not the old contents;
  - bypass applies to both ports independently.
- Address 0 reads always return 0 when ZERO_REG=1, including with a simultaneous write to 0.
- Dump FSM, states IDLE, SCAN, DONE:
  - IDLE: dump_start=1 -> SCAN with idx=0; dump_start is ignored in SCAN and DONE.
  - SCAN: dump_valid=1, dump_busy=1, dump_addr=idx.
  - dump_data = regs[idx] combinationally, as currently stored; a write to idx while stalled updates dump_data the cycle after that write edge.
  - dump_ready=1 with idx<31 -> idx increments and the FSM stays in SCAN.
  - dump_ready=1 with idx==31 -> DONE.
  - dump_ready=0 -> hold; dump_addr does not change.
  - DONE: dump_done=1 for exactly one cycle, dump_valid=0, idx clears to 0 -> IDLE.
  - A dump_start coinciding with DONE is ignored.
- Minimum dump length is 32 beats + 1 done cycle = 33 cycles with dump_ready held high.
- dump_valid never drops before its beat is accepted.
- Writes and port reads are fully functional during a dump; the dump does not stall the pipeline.

Decomposition:
- Shared package/header: REG_ADDR_W=5, REG_DATA_W=32, REG_ZERO=0.
- Dump FSM state encodings ST_IDLE=2'd0, ST_SCAN=2'd1, ST_DONE=2'd2 also live in the shared package.
- One natural sub-module: regfile_dump_ctrl, holding the FSM, index counter and handshake.
  - It drives dump_addr to the storage array's third (combinational) read mux.
  - Storage, the read ports and the bypass stay in the top module.

Test Plan:
- Reset then reads: assert reset_n=0 mid-cycle, release, read addresses 0..31 -> all rd_data = 0x00000000 one cycle after each address is applied.
- Write then read: write 0xDEADBEEF to r5, read A=5 next cycle -> rd_data_a=0xDEADBEEF one edge later.
  - Then write 0x12345678 to r0 and read B=0 -> rd_data_b=0.
- Bypass: same edge wr_en=1, wr_addr=7, wr_data=0xA5A5A5A5, rd_addr_a=7, rd_addr_b=7 (r7 previously 0x1) -> both outputs = 0xA5A5A5A5 after that edge.
- Full dump: load r[i]=i*0x01010101 for i=1..31, pulse dump_start with dump_ready=1:
  - 32 beats, addr 0..31, data 0 then i*0x01010101;
  - dump_done high on cycle 33; dump_busy low afterward.
- Backpressure: during a dump, drop dump_ready for 3 cycles at idx=10 -> dump_addr holds at 10 and dump_valid stays 1.
  - Write r10=0xCAFEF00D during the stall -> dump_data=0xCAFEF00D the next cycle, and beat 10 is accepted with that value.
- Abort and restart: pull reset_n low at idx=20 -> dump_valid, dump_busy and dump_done go 0 immediately and all registers read 0.
  - A new dump_start then runs a complete 32-beat dump of zeros.
